// File: rtl/room_fsm_if.sv
// Button/flag inputs and room-status outputs shared between room_fsm and its driver.
interface room_fsm_if #(parameter int MOVE_W = 8);
    logic              n, s, e, w;
    logic              v;
    logic              sw, win, d;
    logic [6:0]        room;
    logic [MOVE_W-1:0] moves;

    modport master (output n, s, e, w, v, input sw, win, d, room, moves);
    modport slave  (input n, s, e, w, v, output sw, win, d, room, moves);
endinterface

// File: rtl/room_fsm.sv
// Adventure-game room navigator: one-shot button moves, sword-stash request,
// and dragon's-den resolution into win or death.
module room_fsm #(
    parameter int MOVE_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    room_fsm_if.slave  bus
);
    localparam logic [2:0] CAVE   = 3'd0;
    localparam logic [2:0] TUNNEL = 3'd1;
    localparam logic [2:0] RIVER  = 3'd2;
    localparam logic [2:0] STASH  = 3'd3;
    localparam logic [2:0] DEN    = 3'd4;
    localparam logic [2:0] VAULT  = 3'd5;
    localparam logic [2:0] GRAVE  = 3'd6;

    localparam int BN = 3;
    localparam int BS = 2;
    localparam int BE = 1;
    localparam int BW = 0;

    logic [2:0]        state, state_nxt;
    logic [3:0]        btn, prev, press;
    logic              valid, step;
    logic [MOVE_W-1:0] moves_q;

    assign btn   = {bus.n, bus.s, bus.e, bus.w};
    assign press = btn & ~prev;
    assign valid = $onehot(press);

    // prev keeps loading through reset so a button held across release is not a press
    always_ff @(posedge clk)
        prev <= btn;

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        case (state)
            CAVE:
                if (valid && press[BE]) begin state_nxt = TUNNEL; step = 1'b1; end
            TUNNEL:
                if (valid && press[BW])      begin state_nxt = CAVE;  step = 1'b1; end
                else if (valid && press[BS]) begin state_nxt = RIVER; step = 1'b1; end
            RIVER:
                if (valid && press[BN])      begin state_nxt = TUNNEL; step = 1'b1; end
                else if (valid && press[BW]) begin state_nxt = STASH;  step = 1'b1; end
                else if (valid && press[BE]) begin state_nxt = DEN;    step = 1'b1; end
            STASH:
                if (valid && press[BE]) begin state_nxt = RIVER; step = 1'b1; end
            DEN:
                state_nxt = bus.v ? VAULT : GRAVE;
            VAULT, GRAVE:
                state_nxt = state;
            default:
                state_nxt = CAVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CAVE;
            moves_q <= '0;
        end else begin
            state <= state_nxt;
            if (step && moves_q != {MOVE_W{1'b1}})
                moves_q <= moves_q + 1'b1;
        end
    end

    // Outputs depend on registered state only, never on the buttons
    always_comb begin
        bus.room = 7'b0;
        if (state <= GRAVE)
            bus.room[state] = 1'b1;
    end

    assign bus.sw    = (state == STASH);
    assign bus.win   = (state == VAULT);
    assign bus.d     = (state == GRAVE);
    assign bus.moves = moves_q;
endmodule

// File: tb/tb_room_fsm.sv
// Randomised and directed check of room_fsm (MOVE_W=8 and MOVE_W=2 copies in
// lockstep) against a table-driven room/sword model.
module tb_room_fsm;
    logic clk = 1'b0;
    logic reset;

    room_fsm_if #(.MOVE_W(8)) bus8 ();
    room_fsm_if #(.MOVE_W(2)) bus2 ();

    room_fsm #(.MOVE_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    room_fsm #(.MOVE_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    // rooms: 0 cave, 1 tunnel, 2 river, 3 stash, 4 den, 5 vault, 6 grave
    // dirs : 0 N, 1 S, 2 E, 3 W ; -1 means no exit
    int nxt_tbl [4][4];
    int m_room, m_cnt;
    logic m_sword;
    logic [3:0] m_prev;
    int pass_cnt, total_cnt;

    localparam logic [3:0] N = 4'b1000, S = 4'b0100, E = 4'b0010, W = 4'b0001;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_step(input logic [3:0] b, input logic r);
        logic [3:0] pr;
        int old, dir;
        pr = b & ~m_prev;
        m_prev = b;
        old = m_room;
        if (r) begin
            m_room = 0; m_cnt = 0; m_sword = 1'b0;
        end else begin
            if (old == 4) m_room = m_sword ? 5 : 6;
            else if (old < 4 && $countones(pr) == 1) begin
                dir = pr[3] ? 0 : pr[2] ? 1 : pr[1] ? 2 : 3;
                if (nxt_tbl[old][dir] >= 0) begin
                    m_room = nxt_tbl[old][dir];
                    m_cnt++;
                end
            end
            m_sword = m_sword | (old == 3);
        end
        bus8.v = m_sword;
        bus2.v = m_sword;
    endtask

    task automatic check_all();
        check("room8",  int'(bus8.room),  1 << m_room);
        check("sw8",    int'(bus8.sw),    int'(m_room == 3));
        check("win8",   int'(bus8.win),   int'(m_room == 5));
        check("d8",     int'(bus8.d),     int'(m_room == 6));
        check("moves8", int'(bus8.moves), (m_cnt > 255) ? 255 : m_cnt);
        check("room2",  int'(bus2.room),  1 << m_room);
        check("moves2", int'(bus2.moves), (m_cnt > 3) ? 3 : m_cnt);
    endtask

    // drive inputs for the coming edge, then step model and compare after it
    task automatic tick(input logic [3:0] b, input logic r);
        {bus8.n, bus8.s, bus8.e, bus8.w} = b;
        {bus2.n, bus2.s, bus2.e, bus2.w} = b;
        reset = r;
        @(posedge clk);
        #1;
        model_step(b, r);
        check_all();
    endtask

    task automatic press(input logic [3:0] b);
        tick(b, 1'b0);
        tick(4'b0, 1'b0);
    endtask

    initial begin
        nxt_tbl = '{'{-1, -1, 1, -1}, '{-1, 2, -1, 0}, '{1, -1, 4, 3}, '{-1, -1, 2, -1}};
        m_room = 0; m_cnt = 0; m_sword = 1'b0; m_prev = 4'b0;
        pass_cnt = 0; total_cnt = 0;
        bus8.v = 1'b0; bus2.v = 1'b0;

        // held n through reset release is not a press
        tick(N, 1'b1);
        tick(N, 1'b1);
        repeat (3) tick(N, 1'b0);
        check("t1_room", int'(bus8.room), 7'b0000001);
        check("t1_moves", int'(bus8.moves), 0);
        tick(4'b0, 1'b0);
        press(E);
        check("t1_room_e", int'(bus8.room), 7'b0000010);
        check("t1_moves_e", int'(bus8.moves), 1);

        // sword path to victory
        tick(4'b0, 1'b1);
        press(E); press(S); press(W);
        check("t2_stash", int'(bus8.room), 7'b0001000);
        check("t2_sw", int'(bus8.sw), 1);
        tick(4'b0, 1'b0);
        press(E);
        tick(E, 1'b0);
        check("t2_den", int'(bus8.room), 7'b0010000);
        tick(4'b0, 1'b0);
        check("t2_vault", int'(bus8.room), 7'b0100000);
        check("t2_win", int'(bus8.win), 1);
        check("t2_d", int'(bus8.d), 0);
        check("t2_moves", int'(bus8.moves), 5);

        // no sword: death, then terminal
        tick(4'b0, 1'b1);
        press(E); press(S); press(E);
        tick(4'b0, 1'b0);
        check("t3_grave", int'(bus8.room), 7'b1000000);
        check("t3_d", int'(bus8.d), 1);
        press(N); press(W); press(E);
        check("t3_stuck", int'(bus8.room), 7'b1000000);
        check("t3_moves", int'(bus8.moves), 3);

        // simultaneous presses and illegal direction
        tick(4'b0, 1'b1);
        press(S);
        check("t4_cave_s", int'(bus8.room), 7'b0000001);
        press(E); press(S);
        press(N | E);
        check("t4_river", int'(bus8.room), 7'b0000100);
        check("t4_moves", int'(bus8.moves), 2);

        // saturation on the narrow counter
        tick(4'b0, 1'b1);
        repeat (5) begin press(E); press(W); end
        check("t5_moves2", int'(bus2.moves), 3);
        check("t5_moves8", int'(bus8.moves), 10);
        check("t5_room", int'(bus2.room), 7'b0000001);

        // reset while in the den
        tick(4'b0, 1'b1);
        press(E); press(S);
        tick(E, 1'b0);
        check("t6_den", int'(bus8.room), 7'b0010000);
        tick(4'b0, 1'b1);
        check("t6_room", int'(bus8.room), 7'b0000001);
        check("t6_moves", int'(bus8.moves), 0);
        check("t6_win", int'(bus8.win), 0);

        // random walk
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] b;
            logic r;
            r = ($urandom_range(0, 59) == 0);
            b = ($urandom_range(0, 9) < 6) ? 4'b0 : 4'($urandom_range(0, 15));
            tick(b, r);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/room_fsm.md
# room_fsm

Room-navigation controller for the lab 5 adventure game: tracks the player's room from one-shot N/S/E/W button presses and drives the sword-pickup request `sw`. It consumes the has-sword flag `v` that the sword-flag FSM returns, and resolves the Dragon's Den encounter into win or death. It sits beside the sword-flag FSM on the same `clk`/`reset`: `sw` goes out to it and `v` comes back.

## Interface
- MOVE_W, 8, width of the accepted-move counter `moves`
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock; sampled on rising edge of clk
- n  input  1  north button, level, assumed synchronous to clk
- s  input  1  south button
- e  input  1  east button
- w  input  1  west button
- v  input  1  has-sword flag from sword FSM (registered there)
- sw  output  1  high while in Secret Sword Stash (drives sword FSM `sw`)
- win  output  1  high while in Victory Vault
- d  output  1  high while in Grievous Graveyard (dead)
- room  output  7  one-hot current room, bit order below
- moves  output  MOVE_W  count of accepted button moves, saturating

## Operation
- States / room bits: CAVE (Cave of Cacophony, bit0), TUNNEL (Twisty Tunnel, bit1), RIVER (Rapid River, bit2), STASH (Secret Sword Stash, bit3), DEN (Dragon's Den, bit4), VAULT (Victory Vault, bit5), GRAVE (Grievous Graveyard, bit6)
- Button edge detect: `prev` register holds last-cycle {n,s,e,w}; press = input high AND prev low. `prev` loads current inputs every cycle including during reset, so a button held through reset release is not a press.
- Valid press = exactly one of the four presses asserted this cycle; zero or ≥2 simultaneous presses → no move, nothing counted.
- Transitions on valid press (any other direction: stay, not counted):
  - CAVE: E→TUNNEL
  - TUNNEL: W→CAVE, S→RIVER
  - RIVER: N→TUNNEL, W→STASH, E→DEN
  - STASH: E→RIVER
- DEN: unconditional on next edge, buttons ignored; v=1 → VAULT, v=0 → GRAVE.
- VAULT, GRAVE: terminal; buttons ignored until reset.
- `moves` increments by 1 on each accepted transition; saturates at 2^MOVE_W−1; DEN→VAULT/GRAVE not counted.
- Outputs decoded from state register only: sw = (STASH), win = (VAULT), d = (GRAVE), room = one-hot of state. No glitch paths from buttons.
- Reset: state=CAVE, room=7'b0000001, sw=0, win=0, d=0, moves=0. Reset dominates any press in the same cycle; reset mid-game (any state, including DEN) returns to CAVE next edge.

## Timing
- Press first seen high at edge k → room updated after edge k (one-cycle latency); `moves` updates same edge.
- Held button: single move; must return low for ≥1 sampled cycle before next press.
- Entering STASH at edge k: sw=1 after k; sword FSM sets v after edge k+1. Earliest DEN entry is two moves later, so v is always settled when DEN samples it.
- DEN occupies exactly one cycle; VAULT or GRAVE after the following edge.
- Invalid state encodings (unreachable) → CAVE next edge.

## Test plan
- Reset with n held high, release reset, hold n 3 cycles → room=0000001, moves=0; then pulse e 1 cycle → room=0000010, moves=1.
- Path E,S,W (single-cycle pulses, one idle cycle between) → room=0001000, sw=1; with sword FSM attached, v=1 two cycles after entering STASH; then E,E → DEN one cycle, then room=0100000, win=1, d=0, moves=5.
- Path E,S,E without visiting STASH (v=0) → DEN one cycle, then room=1000000, d=1; further presses: room unchanged, moves stays 3.
- In RIVER press n and e same cycle → no move, moves unchanged; press s in CAVE → no move.
- MOVE_W=2: alternate E,W from CAVE 5 times → moves sticks at 3, room toggles correctly.
- Assert reset for one cycle while in DEN → next edge room=0000001, win=0, d=0, moves=0, sw=0.
